// File: rtl/sprite_rom_scheduler.sv
// Time-shares the sprite bitmap ROM between renderer slots during hblank.
// Requests are latched at the first hblank pixel and served lowest index first.
module sprite_rom_scheduler #(
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_CYCLES = 4,
  parameter int ADDR_W      = 4,
  parameter int H_DISPLAY   = 640,
  parameter int H_TOTAL     = 800
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [9:0]                  hpos,
  input  logic [NUM_SLOTS-1:0]        slot_req,
  input  logic [NUM_SLOTS*ADDR_W-1:0] slot_addr,
  input  logic                        overrun_clr,
  output logic [ADDR_W-1:0]           rom_addr,
  output logic [NUM_SLOTS-1:0]        load,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun
);

  // state | meaning
  // IDLE  | waiting for hpos==H_DISPLAY to latch requests
  // GRANT | slot cur owns the ROM; cnt counts 0..SLOT_CYCLES-1
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [9:0] HPOS_FIRST = 10'(H_DISPLAY);
  localparam logic [9:0] HPOS_LAST  = 10'(H_TOTAL - 1);
  localparam logic [3:0] CNT_LAST   = 4'(SLOT_CYCLES - 1);

  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_SLOTS-1:0] m);
    lowest = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (m[i]) lowest = IDX_W'(i);
  endfunction

  function automatic logic [NUM_SLOTS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  logic [0:0]           state;
  logic [NUM_SLOTS-1:0] pending;
  logic [IDX_W-1:0]     cur;
  logic [3:0]           cnt;

  logic [ADDR_W-1:0]    addr_arr [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] remaining;
  logic [IDX_W-1:0]     first_idx;
  logic [IDX_W-1:0]     next_idx;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_addr
    assign addr_arr[g] = slot_addr[g*ADDR_W +: ADDR_W];
  end

  assign remaining = pending & ~onehot(cur);
  assign first_idx = lowest(slot_req);
  assign next_idx  = lowest(remaining);
  assign busy      = |load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      pending  <= '0;
      cur      <= '0;
      cnt      <= '0;
      rom_addr <= '0;
      load     <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (overrun_clr) overrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hpos == HPOS_FIRST) begin
            pending <= slot_req;
            if (slot_req != '0) begin
              state    <= S_GRANT;
              cur      <= first_idx;
              cnt      <= '0;
              load     <= onehot(first_idx);
              rom_addr <= addr_arr[first_idx];
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          // Running out of hblank aborts the line; later assignment makes set win over clear.
          if (hpos == HPOS_LAST) begin
            state   <= S_IDLE;
            pending <= '0;
            load    <= '0;
            overrun <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            pending <= remaining;
            if (remaining != '0) begin
              cur      <= next_idx;
              cnt      <= '0;
              load     <= onehot(next_idx);
              rom_addr <= addr_arr[next_idx];
            end else begin
              state <= S_IDLE;
              load  <= '0;
              done  <= 1'b1;
            end
          end else begin
            cnt      <= cnt + 4'd1;
            rom_addr <= addr_arr[cur];
          end
        end
      endcase
    end
  end

  a_load_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(load));

endmodule
